sin_rom_arb: RTL
================

SIN_ROM_ARB -- requirements
Module: sin_rom_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing one sine ROM (2..8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 12, giving the ROM address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 7, giving the ROM data width.
REQ-004 The block SHALL have parameter ROM_LAT, default 1, giving the ROM read latency in clk cycles (1 = no output register, 2 = output register enabled).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  system clock, all logic on posedge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_valid  input  N_REQ  per-requester read request.
REQ-008 req_addr  input  N_REQ*ADDR_WIDTH  per-requester address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 req_ready  output  N_REQ  one-hot grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
REQ-010 rsp_valid  output  N_REQ  one-hot read-data strobe to the requester that owns rsp_data.
REQ-011 rsp_data  output  DATA_WIDTH  ROM word for the strobed requester.
REQ-012 rom_addr  output  ADDR_WIDTH  address to the ROM instance.
REQ-013 rom_rd_data  input  DATA_WIDTH  data returned by the ROM instance.

Function
REQ-014 At most one requester SHALL be granted per cycle; req_ready SHALL be combinational from req_valid and the priority pointer.
REQ-015 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod N_REQ and grants the first asserted req_valid.
REQ-016 The pointer SHALL update to the granted index only on an accepted request; with no request it holds.
REQ-017 req_ready[i] SHALL be 0 when req_valid[i] is 0.
REQ-018 rom_addr SHALL equal req_addr of the granted requester in the acceptance cycle, and hold its last accepted value when idle.
REQ-019 The block SHALL carry a one-hot tag through a ROM_LAT-deep shift pipeline; the request accepted at cycle T SHALL produce rsp_valid (tag) and rsp_data = rom_rd_data at cycle T+ROM_LAT.
REQ-020 rsp_data SHALL be forwarded from rom_rd_data without extra registering; it is valid only when rsp_valid is nonzero.
REQ-021 Responses SHALL NOT be back-pressured; sustained throughput SHALL be one access per cycle.
REQ-022 Back-to-back grants to different requesters SHALL yield back-to-back responses in grant order.
REQ-023 A requester that keeps req_valid high SHALL be granted at least once every N_REQ cycles (no starvation).
REQ-024 If only one requester is active it SHALL be granted every cycle.
REQ-025 Pointer wrap SHALL go from N_REQ-1 to 0.

Reset
REQ-026 On rst, pointer SHALL be set to N_REQ-1 so requester 0 has first priority.
REQ-027 On rst, tag pipeline SHALL clear; rsp_valid SHALL be 0 in the cycle after rst is sampled and while rst is high.
REQ-028 On rst, rom_addr SHALL reset to 0 and req_ready SHALL be 0 while rst is high.
REQ-029 Requests in flight when rst asserts SHALL be discarded with no response.

Structure
REQ-030 ADDR_WIDTH, DATA_WIDTH and ROM_LAT defaults SHALL live in shared package sin_rom_pkg, next to the ROM geometry constants.
REQ-031 Round-robin selection SHALL be a sub-module rr_arb (inputs req, pointer; outputs one-hot grant, encoded index).
REQ-032 Tag pipeline, address mux and pointer register SHALL be in sin_rom_arb.

Verification
REQ-033 Reset release, only req_valid=4'b0001 addr 0x100 -> req_ready=0001 same cycle, rsp_valid=0001 with ROM word at 0x100 at T+ROM_LAT.
REQ-034 All four valid continuously for 8 cycles after reset -> grants 0,1,2,3,0,1,2,3; responses in same order, one per cycle.
REQ-035 req_valid=4'b1010 after last grant 3 -> grant 1, then 3, then 1; requesters 0/2 never strobed.
REQ-036 rst asserted the cycle after grant with ROM_LAT=2 -> no rsp_valid for that request; first grant after release goes to requester 0.
REQ-037 Idle 5 cycles after grant at addr 0xFFF -> rom_addr stays 0xFFF, rsp_valid stays 0, pointer unchanged.
REQ-038 Run REQ-034 with ROM_LAT=1 and ROM_LAT=2 against a ROM model -> every rsp_data matches model for its tagged address.

Source files
------------

// File: rtl/sin_rom_pkg.sv
// Shared constants for the sine ROM and its read arbiter.
// Holds the ROM geometry and the defaults that sin_rom_arb uses for its
// address width, data width and read latency.
// No ports: this file is a package only.

package sin_rom_pkg;

    localparam int SIN_ROM_ADDR_WIDTH = 12;
    localparam int SIN_ROM_DATA_WIDTH = 7;
    localparam int SIN_ROM_DEPTH      = 1 << SIN_ROM_ADDR_WIDTH;
    // 1 = ROM without output register, 2 = ROM output register enabled
    localparam int SIN_ROM_LAT        = 1;
    localparam int SIN_ROM_N_REQ      = 4;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sin_rom_arb_rr_arb.sv
// Round-robin selector for the sine ROM arbiter.
// Searches i_req starting one position after i_ptr and wrapping at N-1,
// returning the first asserted request as a one-hot grant and its index.
// Ports:
//   i_req   [N-1:0]  request vector
//   i_ptr   [PW-1:0] index of the last granted requester
//   o_grant [N-1:0]  one-hot grant (all zero when no request)
//   o_idx   [PW-1:0] encoded index of the grant (0 when no request)

module rr_arb #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx
);

    logic [PW-1:0] w_cand;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            w_cand = PW'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                w_found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sin_rom_arb.sv
// Shares one sine ROM between N_REQ requesters.
// A round-robin grant picks one requester per cycle; its address is driven
// straight onto rom_addr and a one-hot tag follows it through a ROM_LAT-deep
// pipeline so that the returning ROM word is strobed to the right requester.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   req_valid    per-requester read request
//   req_addr     packed per-requester addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready    one-hot grant (combinational)
//   rsp_valid    one-hot response strobe
//   rsp_data     ROM word for the strobed requester (forwarded from rom_rd_data)
//   rom_addr     address to the ROM
//   rom_rd_data  data from the ROM

module sin_rom_arb
    import sin_rom_pkg::*;
#(
    parameter int N_REQ      = SIN_ROM_N_REQ,
    parameter int ADDR_WIDTH = SIN_ROM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SIN_ROM_DATA_WIDTH,
    parameter int ROM_LAT    = SIN_ROM_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic [ADDR_WIDTH-1:0]       rom_addr,
    input  logic [DATA_WIDTH-1:0]       rom_rd_data
);

    localparam int PW = ptr_width(N_REQ);

    logic [PW-1:0]         r_ptr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [N_REQ-1:0]      r_tag [ROM_LAT];

    logic [N_REQ-1:0]      w_grant;
    logic [PW-1:0]         w_idx;
    logic                  w_accept;

    rr_arb #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // The grant is already masked by req_valid, so any ready bit is an accept.
    assign req_ready = rst ? '0 : w_grant;
    assign w_accept  = |req_ready;

    // ROM address is live in the acceptance cycle; otherwise replay the last one
    // so the ROM input does not toggle while idle.
    assign rom_addr  = w_accept ? req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH] : r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= PW'(N_REQ - 1);
            r_addr <= '0;
        end else if (w_accept) begin
            r_ptr  <= w_idx;
            r_addr <= rom_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= req_ready;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Gating with rst also hides a response that would land during reset.
    assign rsp_valid = rst ? '0 : r_tag[ROM_LAT-1];
    assign rsp_data  = rom_rd_data;

endmodule
